// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- iterative RV32M multiply/divide unit for the execute stage.
//   Multiply: shift-add, MUL_BITS multiplier bits per cycle (XLEN/MUL_BITS cycles).
//   Divide:   restoring divide on magnitudes, one quotient bit per cycle (XLEN cycles).
//   Divide-by-zero and signed overflow finish after one cycle without iterating.
// Ports:
//   clk, rst_n (async active-low), flush (sync abort, drops any result)
//   in_valid/in_ready, in_funct3, in_a, in_b, in_tag  -- request from EX
//   out_valid/out_ready, out_result, out_tag          -- registered result to EX->MEM mux
//   busy                                              -- state != IDLE
module ex_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int N_MUL = XLEN / MUL_BITS;
  localparam int CW    = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [2:0]        fn_q, fn_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Shared iteration registers: {hi,lo} is the 2*XLEN+1 product for multiply;
  // hi is the partial remainder and lo the dividend/quotient for divide.
  logic [XLEN:0]     hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  // op: sign-extended multiplicand, or zero-extended divisor magnitude.
  logic [XLEN:0]     op_q, op_d;
  // neg: multiplier is negative (mul) / quotient must be negated (div).
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;

  // ---------------- multiply step ----------------
  logic                       mul_last;
  logic signed [MUL_BITS:0]   mul_dig;
  logic signed [XLEN+MUL_BITS:0] mul_hi_x, mul_a_x, mul_d_x, mul_sum;
  logic [2*XLEN+MUL_BITS:0]   mul_cat;
  logic [2*XLEN:0]            mul_shift;

  always_comb begin
    mul_last  = (cnt_q == CW'(N_MUL - 1));
    // The top multiplier digit carries the sign weight when rs2 is signed and negative,
    // which folds the signed-multiplier correction into the last iteration.
    mul_dig   = {mul_last & neg_q, lo_q[MUL_BITS-1:0]};
    mul_hi_x  = {{MUL_BITS{hi_q[XLEN]}}, hi_q};
    mul_a_x   = {{MUL_BITS{op_q[XLEN]}}, op_q};
    mul_d_x   = {{XLEN{mul_dig[MUL_BITS]}}, mul_dig};
    mul_sum   = mul_hi_x + mul_a_x * mul_d_x;
    mul_cat   = {mul_sum, lo_q};
    mul_shift = mul_cat[2*XLEN+MUL_BITS:MUL_BITS];
  end

  // ---------------- divide step ----------------
  logic                div_last, div_ge;
  logic [XLEN:0]       div_sh, div_rem;
  logic [XLEN-1:0]     div_quo;

  always_comb begin
    div_last = (cnt_q == CW'(XLEN - 1));
    div_sh   = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_ge   = (div_sh >= op_q);
    div_rem  = div_ge ? (div_sh - op_q) : div_sh;
    div_quo  = {lo_q[XLEN-2:0], div_ge};
  end

  // ---------------- operand decode at accept ----------------
  logic            a_sgn_mul, d_sgn;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn_mul = (in_funct3 == 3'd1) || (in_funct3 == 3'd2);
    d_sgn     = ~in_funct3[0];
    a_mag     = (d_sgn && in_a[XLEN-1]) ? (XLEN'(0) - in_a) : in_a;
    b_mag     = (d_sgn && in_b[XLEN-1]) ? (XLEN'(0) - in_b) : in_b;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    res_d   = res_q;
    tag_d   = tag_q;
    fn_d    = fn_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    case (state_q)
      S_IDLE: if (in_valid && !flush) begin
        fn_d  = in_funct3;
        tag_d = in_tag;
        cnt_d = '0;
        hi_d  = '0;
        if (!in_funct3[2]) begin
          state_d = S_MUL;
          op_d    = {a_sgn_mul & in_a[XLEN-1], in_a};
          lo_d    = in_b;
          neg_d   = (in_funct3 == 3'd1) & in_b[XLEN-1];
        end else if (in_b == '0) begin
          state_d = S_DONE;
          res_d   = in_funct3[1] ? in_a : '1;
        end else if (d_sgn && in_a == MIN_INT && in_b == '1) begin
          state_d = S_DONE;
          res_d   = in_funct3[1] ? '0 : MIN_INT;
        end else begin
          state_d = S_DIV;
          lo_d    = a_mag;
          op_d    = {1'b0, b_mag};
          neg_d   = d_sgn & (in_a[XLEN-1] ^ in_b[XLEN-1]);
          rneg_d  = d_sgn & in_a[XLEN-1];
        end
      end
      S_MUL: begin
        hi_d  = mul_shift[2*XLEN:XLEN];
        lo_d  = mul_shift[XLEN-1:0];
        cnt_d = cnt_q + 1'b1;
        if (mul_last) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          res_d   = (fn_q == 3'd0) ? mul_shift[XLEN-1:0] : mul_shift[2*XLEN-1:XLEN];
        end
      end
      S_DIV: begin
        hi_d  = div_rem;
        lo_d  = div_quo;
        cnt_d = cnt_q + 1'b1;
        if (div_last) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          if (fn_q[1]) res_d = rneg_q ? (XLEN'(0) - div_rem[XLEN-1:0]) : div_rem[XLEN-1:0];
          else         res_d = neg_q  ? (XLEN'(0) - div_quo) : div_quo;
        end
      end
      default: begin
        // Special cases enter DONE with valid low so the result appears one cycle later.
        if (!valid_q) valid_d = 1'b1;
        else if (out_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      tag_q   <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE) & ~flush;
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_tag    = tag_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit. Stimulus pushes expected {result,tag} into a
// scoreboard queue; a monitor pops and compares on every output handshake.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] sb[$];

  ex_muldiv_unit #(.XLEN(32), .MUL_BITS(2), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("result", out_result, e[36:5]);
        chk("tag", {27'd0, out_tag}, {27'd0, e[4:0]});
      end
    end
  end

  // Issue one op starting just after a posedge in IDLE; checks latency and,
  // if hold>0, that the result is held while out_ready is low.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input int lat,
                       input int hold);
    sb.push_back({exp, tag});
    out_ready = (hold == 0);
    in_funct3 = f; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept: the unit must have latched them.
    in_valid = 1'b0; in_funct3 = ~f; in_a = $urandom; in_b = $urandom; in_tag = ~tag;
    @(negedge clk);
    chk("valid_low_after_accept", {31'd0, out_valid}, 32'd0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk((i < lat) ? "valid_early" : "valid_at_latency", {31'd0, out_valid}, {31'd0, i == lat});
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_result", out_result, exp);
        chk("hold_tag", {27'd0, out_tag}, {27'd0, tag});
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("idle_after_handshake", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply
    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 16, 0);
    do_op(3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 16, 0);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 16, 0);
    do_op(3'd2, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, 16, 0);
    // Divide
    do_op(3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       32, 0);
    do_op(3'd6, 32'hFFFFFF9C, 32'd7,        5'd8,  32'hFFFFFFFE, 32, 0);
    do_op(3'd4, 32'hFFFFFF9C, 32'd7,        5'd9,  32'hFFFFFFF2, 32, 0);
    do_op(3'd7, 32'd100,      32'd7,        5'd10, 32'd2,        32, 0);
    do_op(3'd4, 32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 32, 0);
    do_op(3'd6, 32'd7,        32'hFFFFFFFE, 5'd12, 32'd1,        32, 0);
    do_op(3'd5, 32'hFFFFFFFF, 32'd1,        5'd13, 32'hFFFFFFFF, 32, 0);
    do_op(3'd7, 32'hFFFFFFFF, 32'h10,       5'd14, 32'hF,        32, 0);
    // Special cases
    do_op(3'd4, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1, 0);
    do_op(3'd6, 32'd5,        32'd0,        5'd16, 32'd5,        1, 0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1, 0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1, 0);
    // Backpressure: hold 10 cycles in DONE
    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd19, 32'hFFFFFFEB, 16, 10);

    // Flush mid-divide at T+5
    in_funct3 = 3'd4; in_a = 32'hFFFFFF9C; in_b = 32'd7; in_tag = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("flush_blocks_accept", {31'd0, busy}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back after flush
    do_op(3'd4, 32'hFFFFFF9C, 32'd7,        5'd21, 32'hFFFFFFF2, 32, 0);
    do_op(3'd5, 32'd100,      32'd7,        5'd22, 32'd14,       32, 0);

    // Reset pulse mid-multiply
    in_funct3 = 3'd0; in_a = 32'd7; in_b = 32'd9; in_tag = 5'd23; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'd0, 32'd7,        32'd9,        5'd24, 32'd63,       16, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
